// File: rtl/hid2ps2_mod_events.sv
// hid2ps2_mod_events: turns the USB HID modifier byte into PS/2 make/break
// events on a valid/ready handshake, plus a per-modifier level vector.
// The last usb sample (target) is compared with the state already reported
// to the consumer (cur). The lowest differing modifier becomes the next event.
// Optional feature macro: HID2PS2_MOD_SERIAL_EN
//   undefined : one 9-bit word per event (bit 8 = E0-extended)
//   defined   : each event is sent as raw bytes E0 (if extended), F0 (if
//               break), code; evt_code[8] marks the last byte of the event.
module hid2ps2_mod_events #(
   parameter int MOD_BITS = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    usb_valid,
   input  logic [MOD_BITS-1:0]     usb,
   output logic                    evt_valid,
   input  logic                    evt_ready,
   output logic [8:0]              evt_code,
   output logic                    evt_break,
   output logic [9*MOD_BITS-1:0]   ps2,
   output logic                    busy
);

   localparam int IDX_W = (MOD_BITS > 1) ? $clog2(MOD_BITS) : 1;

   // Scancode for modifier bit i; bit 8 flags an E0-prefixed key.
   function automatic logic [8:0] code_of(input int i);
      logic [8:0] c;
      case (i)
         0:       c = 9'h014;   // LCtrl
         1:       c = 9'h012;   // LShift
         2:       c = 9'h011;   // LAlt
         3:       c = 9'h11F;   // LGUI
         4:       c = 9'h114;   // RCtrl
         5:       c = 9'h059;   // RShift
         6:       c = 9'h111;   // RAlt
         7:       c = 9'h127;   // RGUI
         default: c = 9'h000;
      endcase
      return c;
   endfunction

`ifdef HID2PS2_MOD_SERIAL_EN
   typedef enum logic [1:0] {S_IDLE, S_PFX_E0, S_PFX_F0, S_CODE} state_t;
`else
   typedef enum logic {S_IDLE, S_EMIT} state_t;
`endif

   state_t               state_q, state_d;
   logic [MOD_BITS-1:0]  target_q, target_d;
   logic [MOD_BITS-1:0]  cur_q, cur_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [8:0]           code_q, code_d;
   logic                 brk_q, brk_d;

   logic [MOD_BITS-1:0]  diff;
   logic [IDX_W-1:0]     scan_idx;

   assign diff = target_q ^ cur_q;

   // Priority scan: lowest differing modifier wins, press or release alike.
   always_comb begin
      scan_idx = '0;
      for (int i = MOD_BITS - 1; i >= 0; i--) begin
         if (diff[i]) scan_idx = IDX_W'(i);
      end
   end

   // Next-state logic: latch an event from IDLE, retire it on the final handshake.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      code_d   = code_q;
      brk_d    = brk_q;
      cur_d    = cur_q;
      // Input is never back-pressured; a sample at an accept edge still lands.
      target_d = usb_valid ? usb : target_q;
      case (state_q)
         S_IDLE: begin
            if (diff != '0) begin
               idx_d  = scan_idx;
               code_d = code_of(int'(scan_idx));
               brk_d  = cur_q[scan_idx];
`ifdef HID2PS2_MOD_SERIAL_EN
               if (code_of(int'(scan_idx)) >= 9'h100) state_d = S_PFX_E0;
               else if (cur_q[scan_idx])               state_d = S_PFX_F0;
               else                                    state_d = S_CODE;
`else
               state_d = S_EMIT;
`endif
            end
         end
`ifdef HID2PS2_MOD_SERIAL_EN
         S_PFX_E0: begin
            if (evt_ready) state_d = brk_q ? S_PFX_F0 : S_CODE;
         end
         S_PFX_F0: begin
            if (evt_ready) state_d = S_CODE;
         end
         S_CODE: begin
            if (evt_ready) begin
               cur_d[idx_q] = ~cur_q[idx_q];
               state_d      = S_IDLE;
            end
         end
`else
         S_EMIT: begin
            if (evt_ready) begin
               cur_d[idx_q] = ~cur_q[idx_q];
               state_d      = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset drops any in-flight event and forgets held keys.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         target_q <= '0;
         cur_q    <= '0;
         idx_q    <= '0;
         code_q   <= '0;
         brk_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         cur_q    <= cur_d;
         idx_q    <= idx_d;
         code_q   <= code_d;
         brk_q    <= brk_d;
      end
   end

   // Event outputs depend only on registers, so they stay stable while stalled.
   always_comb begin
      evt_valid = (state_q != S_IDLE);
      evt_break = (state_q != S_IDLE) ? brk_q : 1'b0;
      evt_code  = 9'h000;
      busy      = (state_q != S_IDLE) || (diff != '0);
      case (state_q)
`ifdef HID2PS2_MOD_SERIAL_EN
         S_PFX_E0: evt_code = {1'b0, 8'hE0};
         S_PFX_F0: evt_code = {1'b0, 8'hF0};
         S_CODE:   evt_code = {1'b1, code_q[7:0]};
`else
         S_EMIT:   evt_code = code_q;
`endif
         default:  evt_code = 9'h000;
      endcase
   end

   // Level vector follows the reported state, entry 0 in the top slot.
   genvar gi;
   generate
      for (gi = 0; gi < MOD_BITS; gi++) begin : g_ps2
         assign ps2[9*(MOD_BITS-1-gi) +: 9] = cur_q[gi] ? code_of(gi) : 9'h000;
      end
   endgenerate

endmodule

// File: tb/tb_hid2ps2_mod_events.sv
// Self-checking bench for hid2ps2_mod_events (MOD_BITS = 8). A transaction
// model tracks what the consumer has been told (m_cur), the latest usb sample
// (m_tgt) and the event currently offered, and the outputs are checked
// against it. Build with HID2PS2_MOD_SERIAL_EN for the byte-stream variant.
module tb_hid2ps2_mod_events;

   logic        clk = 1'b0;
   logic        reset;
   logic        usb_valid;
   logic [7:0]  usb;
   logic        evt_valid;
   logic        evt_ready;
   logic [8:0]  evt_code;
   logic        evt_break;
   logic [71:0] ps2;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   // model state
   logic [7:0] m_tgt = 8'h00;
   logic [7:0] m_cur = 8'h00;
   bit         m_pend = 1'b0;
   int         m_idx = 0;
   bit         m_brk = 1'b0;

   logic [8:0] TBL [8] = '{9'h014, 9'h012, 9'h011, 9'h11F, 9'h114, 9'h059, 9'h111, 9'h127};

   always #5 clk = ~clk;

   hid2ps2_mod_events #(.MOD_BITS(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .usb_valid (usb_valid),
      .usb       (usb),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_code  (evt_code),
      .evt_break (evt_break),
      .ps2       (ps2),
      .busy      (busy)
   );

   function automatic logic [71:0] exp_ps2(input logic [7:0] c);
      logic [71:0] r = '0;
      for (int i = 0; i < 8; i++) if (c[i]) r[9*(7-i) +: 9] = TBL[i];
      return r;
   endfunction

   function automatic int lowest(input logic [7:0] d);
      for (int i = 0; i < 8; i++) if (d[i]) return i;
      return -1;
   endfunction

   // Drive one cycle and advance the model across the clock edge.
   // An idle consumer picks up the lowest pending change; a handshake on an
   // offered event commits it; the next event is considered one edge later.
   task automatic step(input logic v, input logic [7:0] u, input logic r);
      usb_valid = v; usb = u; evt_ready = r;
      @(posedge clk);
      if (!m_pend && (m_tgt != m_cur)) begin
         m_pend = 1'b1;
         m_idx  = lowest(m_tgt ^ m_cur);
         m_brk  = m_cur[m_idx];
      end else if (m_pend && r) begin
         $display("EVENT accepted code=%03h break=%0d", TBL[m_idx], m_brk);
         m_cur[m_idx] = ~m_cur[m_idx];
         m_pend = 1'b0;
      end
      if (v) m_tgt = u;
      #1;
   endtask

   task automatic release_all();
      step(1'b1, 8'h00, 1'b1);
      for (int c = 0; c < 40 && busy; c++) step(1'b0, 8'h00, 1'b1);
      checks++;
      if (busy !== 1'b0 || ps2 !== 72'h0) begin
         failures++; $display("FAIL release_drain busy=%0d ps2=%h required busy=0 ps2=0", busy, ps2);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; usb_valid = 1'b0; usb = 8'h00; evt_ready = 1'b0;
      #1;
      checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", evt_valid); end
      checks++; if (evt_code !== 9'h000) begin failures++; $display("FAIL reset_code got=%h exp=000", evt_code); end
      checks++; if (evt_break !== 1'b0) begin failures++; $display("FAIL reset_break got=%0h exp=0", evt_break); end
      checks++; if (ps2 !== 72'h0) begin failures++; $display("FAIL reset_ps2 got=%h exp=0", ps2); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (evt_valid !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL post_reset valid=%0h busy=%0h exp 0/0", evt_valid, busy);
      end
      $display("TXN reset done");
   endtask

`ifdef HID2PS2_MOD_SERIAL_EN
   // Collect the byte stream of one usb change with evt_ready held high.
   task automatic collect(input logic [7:0] u, output logic [9:0] got [$]);
      got = {};
      usb_valid = 1'b1; usb = u; evt_ready = 1'b1;
      @(posedge clk); #1;
      usb_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (evt_valid) begin
            got.push_back({evt_break, evt_code});
            $display("TXN byte code=%03h break=%0d", evt_code, evt_break);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_serial();
      logic [9:0] got [$];
      logic [9:0] exp_mk [$];
      logic [9:0] exp_br [$];
      exp_mk = '{{1'b0, 9'h0E0}, {1'b0, 9'h127}};
      exp_br = '{{1'b1, 9'h0E0}, {1'b1, 9'h0F0}, {1'b1, 9'h127}};
      collect(8'h80, got);
      checks++; if (got.size() != exp_mk.size()) begin
         failures++; $display("FAIL serial_make_len got=%0d exp=%0d", got.size(), exp_mk.size());
      end else begin
         for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] !== exp_mk[i]) begin
               failures++; $display("FAIL serial_make_byte%0d got=%h exp=%h", i, got[i], exp_mk[i]);
            end
         end
      end
      collect(8'h00, got);
      checks++; if (got.size() != exp_br.size()) begin
         failures++; $display("FAIL serial_break_len got=%0d exp=%0d", got.size(), exp_br.size());
      end else begin
         for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] !== exp_br[i]) begin
               failures++; $display("FAIL serial_break_byte%0d got=%h exp=%h", i, got[i], exp_br[i]);
            end
         end
      end
      checks++; if (ps2 !== 72'h0) begin failures++; $display("FAIL serial_ps2 got=%h exp=0", ps2); end
   endtask
`else
   task automatic test_single_make();
      step(1'b1, 8'h02, 1'b0);   // edge N
      checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL make_latency valid=%0h exp=0", evt_valid); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL make_busy got=%0h exp=1", busy); end
      step(1'b0, 8'h02, 1'b0);   // edge N+1
      checks++; if (evt_valid !== 1'b1 || evt_code !== 9'h012 || evt_break !== 1'b0) begin
         failures++; $display("FAIL make_event valid=%0h code=%h brk=%0h exp 1/012/0", evt_valid, evt_code, evt_break);
      end
      checks++; if (ps2[62:54] !== 9'h000) begin failures++; $display("FAIL make_ps2_early got=%h exp=000", ps2[62:54]); end
      step(1'b0, 8'h02, 1'b1);   // accept
      checks++; if (ps2[62:54] !== 9'h012) begin failures++; $display("FAIL make_ps2 got=%h exp=012", ps2[62:54]); end
      checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL make_bubble valid=%0h exp=0", evt_valid); end
      release_all();
   endtask

   task automatic test_two_events();
      logic [8:0] codes [$];
      int         cyc [$];
      step(1'b1, 8'h81, 1'b1);
      for (int c = 0; c < 12; c++) begin
         if (evt_valid) begin
            codes.push_back(evt_code); cyc.push_back(c);
            $display("TXN two_events code=%03h break=%0d cycle=%0d", evt_code, evt_break, c);
         end
         step(1'b0, 8'h81, 1'b1);
      end
      checks++; if (codes.size() != 2) begin
         failures++; $display("FAIL two_count got=%0d exp=2", codes.size());
      end else begin
         checks++; if (codes[0] !== 9'h014) begin failures++; $display("FAIL two_first got=%h exp=014", codes[0]); end
         checks++; if (codes[1] !== 9'h127) begin failures++; $display("FAIL two_second got=%h exp=127", codes[1]); end
         checks++; if (cyc[1] - cyc[0] != 2) begin failures++; $display("FAIL two_spacing got=%0d exp=2", cyc[1] - cyc[0]); end
      end
      checks++; if (ps2 !== exp_ps2(8'h81)) begin failures++; $display("FAIL two_ps2 got=%h exp=%h", ps2, exp_ps2(8'h81)); end
      release_all();
   endtask

   task automatic test_stall();
      int bad = 0;
      step(1'b1, 8'h10, 1'b0);
      step(1'b0, 8'h10, 1'b0);
      for (int c = 0; c < 10; c++) begin
         checks++;
         if (evt_valid !== 1'b1 || evt_code !== 9'h114 || evt_break !== 1'b0 || busy !== 1'b1 || ps2 !== 72'h0) begin
            failures++; bad++;
            $display("FAIL stall_hold c=%0d valid=%0h code=%h brk=%0h busy=%0h ps2=%h exp 1/114/0/1/0",
                     c, evt_valid, evt_code, evt_break, busy, ps2);
         end
         step(1'b0, 8'h10, 1'b0);
      end
      $display("TXN stall held 10 cycles, bad=%0d", bad);
      step(1'b0, 8'h10, 1'b1);
      checks++; if (ps2[35:27] !== 9'h114) begin failures++; $display("FAIL stall_ps2 got=%h exp=114", ps2[35:27]); end
      release_all();
   endtask

   task automatic test_coalesce();
      int n_evt = 0;
      int n_b1  = 0;
      step(1'b1, 8'h01, 1'b0);   // target = 01
      step(1'b1, 8'h03, 1'b0);   // bit 0 latched, bit 1 pressed
      step(1'b1, 8'h01, 1'b0);   // bit 1 released before it could be latched
      checks++; if (evt_code !== 9'h014 || evt_valid !== 1'b1) begin
         failures++; $display("FAIL coal_first valid=%0h code=%h exp 1/014", evt_valid, evt_code);
      end
      for (int c = 0; c < 8; c++) begin
         if (evt_valid) begin
            n_evt++;
            if (evt_code == 9'h012) n_b1++;
            $display("TXN coalesce code=%03h break=%0d", evt_code, evt_break);
         end
         step(1'b0, 8'h01, 1'b1);
      end
      checks++; if (n_b1 != 0) begin failures++; $display("FAIL coal_bit1 got=%0d events exp=0", n_b1); end
      checks++; if (n_evt != 1) begin failures++; $display("FAIL coal_count got=%0d exp=1", n_evt); end
      checks++; if (ps2 !== exp_ps2(8'h01)) begin failures++; $display("FAIL coal_ps2 got=%h exp=%h", ps2, exp_ps2(8'h01)); end
      release_all();
   endtask

   task automatic test_random();
      logic       v;
      logic [7:0] u;
      logic       r;
      for (int c = 0; c < 250; c++) begin
         checks++; if (evt_valid !== m_pend) begin
            failures++; $display("FAIL rnd_valid c=%0d got=%0h exp=%0h", c, evt_valid, m_pend);
         end
         if (m_pend) begin
            checks++; if (evt_code !== TBL[m_idx] || evt_break !== m_brk) begin
               failures++; $display("FAIL rnd_event c=%0d code=%h brk=%0h exp=%h/%0h", c, evt_code, evt_break, TBL[m_idx], m_brk);
            end
         end
         checks++; if (ps2 !== exp_ps2(m_cur)) begin
            failures++; $display("FAIL rnd_ps2 c=%0d got=%h exp=%h", c, ps2, exp_ps2(m_cur));
         end
         checks++; if (busy !== (m_pend || (m_tgt != m_cur))) begin
            failures++; $display("FAIL rnd_busy c=%0d got=%0h exp=%0h", c, busy, (m_pend || (m_tgt != m_cur)));
         end
         v = ($urandom_range(0, 3) == 0);
         u = 8'($urandom);
         r = 1'($urandom_range(0, 1));
         step(v, u, r);
      end
      release_all();
   endtask

   task automatic test_reset_mid();
      step(1'b1, 8'h01, 1'b0);
      step(1'b0, 8'h01, 1'b0);
      checks++; if (evt_valid !== 1'b1) begin failures++; $display("FAIL rmid_pending got=%0h exp=1", evt_valid); end
      #2 reset = 1'b1;
      #1;
      checks++; if (evt_valid !== 1'b0 || ps2 !== 72'h0 || busy !== 1'b0) begin
         failures++; $display("FAIL rmid_clear valid=%0h ps2=%h busy=%0h exp 0/0/0", evt_valid, ps2, busy);
      end
      m_tgt = 8'h00; m_cur = 8'h00; m_pend = 1'b0;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      #1;
      step(1'b1, 8'h01, 1'b0);
      step(1'b0, 8'h01, 1'b0);
      checks++; if (evt_valid !== 1'b1 || evt_code !== 9'h014 || evt_break !== 1'b0) begin
         failures++; $display("FAIL rmid_remake valid=%0h code=%h brk=%0h exp 1/014/0", evt_valid, evt_code, evt_break);
      end
      step(1'b0, 8'h01, 1'b1);
      checks++; if (ps2[71:63] !== 9'h014) begin failures++; $display("FAIL rmid_ps2 got=%h exp=014", ps2[71:63]); end
      release_all();
   endtask
`endif

   initial begin
      test_reset();
`ifdef HID2PS2_MOD_SERIAL_EN
      test_serial();
`else
      test_single_make();
      test_two_events();
      test_stall();
      test_coalesce();
      test_random();
      test_reset_mid();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hid2ps2_mod_events.md
# hid2ps2_mod_events

Converts the USB HID keyboard modifier byte into discrete PS/2 make/break events with a valid/ready handshake, plus a registered per-modifier level vector. It sits between the Analogue Pocket HID keyboard decoder and the core's PS/2 keyboard path, replacing level-only modifier translation. Cores that consume change events or a byte stream can then observe Ctrl/Shift/Alt/GUI transitions without edge detection of their own.

## Interface
- MOD_BITS, 8, number of modifier bits handled (1..8); bit i maps to table entry i.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- usb_valid  in  1  strobe: usb carries a new modifier sample.
- usb  in  MOD_BITS  HID modifier bits (0 LCtrl, 1 LShift, 2 LAlt, 3 LGUI, 4 RCtrl, 5 RShift, 6 RAlt, 7 RGUI).
- evt_valid  out  1  event or byte available.
- evt_ready  in  1  consumer accepts when high with evt_valid.
- evt_code  out  9  event scancode, bit 8 = E0-extended (see Configuration for serial mode).
- evt_break  out  1  1 = release (break), 0 = press (make).
- ps2  out  9*MOD_BITS  level vector: entry i at ps2[9*(MOD_BITS-1-i)+8 : 9*(MOD_BITS-1-i)], holds code when reported-pressed, else 0.
- busy  out  1  target differs from reported state, or an event/byte is pending.

## Operation
- Code table: 0→014, 1→012, 2→011, 3→11F, 4→114, 5→059, 6→111, 7→127.
- Registers: target[MOD_BITS] (last usb sample), cur[MOD_BITS] (state reported to consumer).
- usb_valid high at an edge: target <= usb. Accepted any time; no back-pressure on input.
- diff = target ^ cur. Scanner selects the lowest set index of diff, regardless of direction.
- FSM (word mode): IDLE → EMIT when diff ≠ 0; evt_code = table[idx], evt_break = cur[idx]. EMIT holds all outputs stable until evt_valid && evt_ready; on that edge cur[idx] toggles and FSM → IDLE.
- Coalescing: if target returns to cur before an event is latched, no event is generated. An event already presented is never withdrawn; the opposite transition follows as a new event.
- ps2 is derived from cur, so level vector and event stream agree.

## Timing
- Reset values: cur = 0, target = 0, evt_valid = 0, evt_code = 0, evt_break = 0, ps2 = 0, busy = 0, FSM IDLE.
- Latency: usb_valid sampled at edge N → evt_valid high after edge N+1.
- Throughput: one event per 2 cycles in word mode (one IDLE bubble after each acceptance).
- ps2 entry updates at the edge that accepts the corresponding event.
- usb_valid at the same edge as acceptance: cur toggles and target updates; the next diff uses both new values.
- Reset mid-event: the event is dropped and state cleared. Keys still held are re-reported as makes after the next usb_valid.
- evt_ready high while evt_valid is low has no effect.

## Configuration
- HID2PS2_MOD_SERIAL_EN defined: each event expands into raw PS/2 bytes in order: E0 (if extended), F0 (if break), then code[7:0].
  - evt_code[7:0] carries the byte; evt_code[8] = 1 only on the final byte of the event.
  - evt_break is constant across the event's bytes.
  - FSM: IDLE → PFX_E0 → PFX_F0 → CODE, skipping unneeded prefix states. Each byte needs its own handshake.
  - cur toggles on acceptance of the final byte.
- Not defined: word mode as above; no prefix states.

## Test plan
- Reset, then usb_valid with usb = 8'h02 → one event: evt_code = 9'h012, evt_break = 0, valid after edge N+1; ps2[62:54] = 9'h012 after acceptance.
- usb = 8'h81 from 0, evt_ready held high → two events in order: 014 make, then 127 make, spaced 2 cycles apart.
- Hold evt_ready low 10 cycles with usb 0→0x10 → evt_code = 9'h114 stable throughout; busy = 1; cur unchanged until ready.
- Press then release bit 1 within one cycle before latch (usb 0x02 then 0x00 on consecutive cycles, FSM busy with bit 0) → no bit-1 event emitted.
- Serial build: release RGUI (0x80→0) → bytes E0, F0, 27 with evt_code[8] = 0, 0, 1 and evt_break = 1 on each.
- Assert reset while an event is pending → evt_valid = 0 and ps2 = 0 immediately; after usb_valid 0x01, the 014 make is re-emitted.
